// File: rtl/rr_arbiter_wlock_if.sv
// Request/grant bundle between input-port route logic and the
// output-port round-robin arbiter.
interface rr_arbiter_wlock_if #(
    parameter int N_REQ    = 4,
    parameter int WEIGHT_W = 3
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]          req_i;
    logic [N_REQ*WEIGHT_W-1:0] weight_i;
    logic                      update_i;
    logic                      last_i;
    logic [N_REQ-1:0]          grant_o;
    logic [IDX_W-1:0]          grant_idx_o;
    logic                      grant_valid_o;
    logic                      locked_o;

    modport master (
        output req_i, weight_i, update_i, last_i,
        input  grant_o, grant_idx_o, grant_valid_o, locked_o
    );

    modport slave (
        input  req_i, weight_i, update_i, last_i,
        output grant_o, grant_idx_o, grant_valid_o, locked_o
    );
endinterface

// File: rtl/rr_arbiter_wlock.sv
// N-way weighted round-robin arbiter with wormhole packet lock.
// Grant is combinational; state moves only on accepted beats.
module rr_arbiter_wlock #(
    parameter int N_REQ    = 4,
    parameter int WEIGHT_W = 3,
    parameter int LOCK_EN  = 1
) (
    input logic               clk,
    input logic               arst,
    rr_arbiter_wlock_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [N_REQ-1:0]    mask_q, mask_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]    owner_q, owner_d;

    logic [N_REQ-1:0]    masked;
    logic [IDX_W-1:0]    m_idx, r_idx, win_idx;
    logic                gnt_any;
    logic [WEIGHT_W-1:0] w_arr [N_REQ];
    logic [WEIGHT_W-1:0] win_w, cur_credit;
    logic                beat_end, lock_go;

    always_comb begin
        masked = bus.req_i & mask_q;
        m_idx  = '0;
        r_idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (masked[i]) m_idx = IDX_W'(i);
            if (bus.req_i[i]) r_idx = IDX_W'(i);
            w_arr[i] = bus.weight_i[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    always_comb begin
        win_idx = '0;
        gnt_any = 1'b0;
        unique case (state_q)
            ST_LOCKED: begin
                gnt_any = bus.req_i[lock_idx_q];
                win_idx = gnt_any ? lock_idx_q : '0;
            end
            default: begin
                gnt_any = |bus.req_i;
                win_idx = (|masked) ? m_idx : r_idx;
            end
        endcase
    end

    assign bus.grant_o       = gnt_any ? (N_REQ'(1) << win_idx) : '0;
    assign bus.grant_idx_o   = win_idx;
    assign bus.grant_valid_o = gnt_any;
    assign bus.locked_o      = (state_q == ST_LOCKED);

    // Credit belongs to the winner that owns the mask origin; a new
    // winner starts its turn from zero rather than inheriting it.
    assign win_w      = w_arr[win_idx];
    assign cur_credit = (win_idx == owner_q) ? credit_q : '0;
    assign beat_end   = bus.update_i & gnt_any;
    assign lock_go    = (LOCK_EN != 0) & ~bus.last_i;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        credit_d   = credit_q;
        lock_idx_d = lock_idx_q;
        owner_d    = owner_q;
        unique case (1'b1)
            !beat_end: ;
            beat_end && lock_go: begin
                state_d    = ST_LOCKED;
                lock_idx_d = win_idx;
            end
            default: begin
                state_d = ST_ARB;
                owner_d = win_idx;
                if (cur_credit < win_w) begin
                    credit_d = cur_credit + WEIGHT_W'(1);
                    for (int i = 0; i < N_REQ; i++)
                        mask_d[i] = (IDX_W'(i) >= win_idx);
                end else begin
                    credit_d = '0;
                    for (int i = 0; i < N_REQ; i++)
                        mask_d[i] = (IDX_W'(i) > win_idx);
                    if (win_idx == IDX_W'(N_REQ - 1))
                        mask_d = '1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= ST_ARB;
            mask_q     <= '1;
            credit_q   <= '0;
            lock_idx_q <= '0;
            owner_q    <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            credit_q   <= credit_d;
            lock_idx_q <= lock_idx_d;
            owner_q    <= owner_d;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_wlock.sv
// Bench for rr_arbiter_wlock: vector table, corner sequences and
// random traffic against a pointer-based priority model.
module tb_rr_arbiter_wlock;
    localparam int N  = 4;
    localparam int WW = 3;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] wt;
        bit          upd;
        bit          last;
        int          eidx;
        bit          evalid;
        bit          elock;
    } vec_t;

    logic clk;
    logic arst;
    int   tests;
    int   fails;

    // model: priority starts at ptr and searches circularly
    int m_ptr, m_cnt, m_owner, m_lidx;
    bit m_locked;

    rr_arbiter_wlock_if #(.N_REQ(N), .WEIGHT_W(WW)) bus ();

    rr_arbiter_wlock #(.N_REQ(N), .WEIGHT_W(WW), .LOCK_EN(1)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] wp(input int w0, w1, w2, w3);
        return {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endfunction

    task automatic mdl_reset();
        m_ptr = 0; m_cnt = 0; m_owner = 0; m_lidx = 0; m_locked = 0;
    endtask

    task automatic mdl_grant(input logic [3:0] req,
                             output int g, output bit v);
        g = 0; v = 0;
        if (m_locked) begin
            v = req[m_lidx];
            g = v ? m_lidx : 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!v && req[j]) begin g = j; v = 1; end
            end
        end
    endtask

    task automatic mdl_step();
        int g, c, w;
        bit v;
        mdl_grant(bus.req_i, g, v);
        if (bus.update_i && v) begin
            if (!bus.last_i) begin
                m_locked = 1; m_lidx = g;
            end else begin
                m_locked = 0;
                c = (g == m_owner) ? m_cnt : 0;
                w = int'(bus.weight_i[g*WW +: WW]);
                if (c < w) begin m_cnt = c + 1; m_ptr = g; end
                else begin m_cnt = 0; m_ptr = (g + 1) % N; end
                m_owner = g;
            end
        end
    endtask

    task automatic chk(input string nm, input bit v, input int idx,
                       input bit lk);
        logic [3:0] eg;
        eg = v ? (4'b0001 << idx) : 4'b0000;
        tests++;
        if (bus.grant_o !== eg || bus.grant_idx_o !== 2'(idx) ||
            bus.grant_valid_o !== v || bus.locked_o !== lk) begin
            fails++;
            $display("FAIL %s: got grant=%b idx=%0d valid=%b locked=%b, want grant=%b idx=%0d valid=%b locked=%b",
                     nm, bus.grant_o, bus.grant_idx_o, bus.grant_valid_o,
                     bus.locked_o, eg, idx, v, lk);
        end
    endtask

    task automatic chk_model(input string nm);
        int g;
        bit v;
        mdl_grant(bus.req_i, g, v);
        chk(nm, v, g, m_locked);
    endtask

    task automatic drive(input logic [3:0] req, input logic [11:0] wt,
                         input bit upd, input bit last);
        @(negedge clk);
        bus.req_i = req; bus.weight_i = wt;
        bus.update_i = upd; bus.last_i = last;
        #1;
        chk_model("model");
    endtask

    task automatic adv();
        @(posedge clk);
        mdl_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 arst = 1'b0;
        mdl_reset();
        #1;
        @(negedge clk);
        arst = 1'b1;
    endtask

    vec_t tbl[$];

    task automatic add(input logic [3:0] r, input logic [11:0] w,
                       input bit u, input bit l, input int ei,
                       input bit ev, input bit el);
        vec_t t;
        t.req = r; t.wt = w; t.upd = u; t.last = l;
        t.eidx = ei; t.evalid = ev; t.elock = el;
        tbl.push_back(t);
    endtask

    initial begin
        tests = 0; fails = 0;
        arst = 1'b0;
        bus.req_i = '0; bus.weight_i = '0;
        bus.update_i = 1'b0; bus.last_i = 1'b0;
        mdl_reset();
        #2;
        chk("reset_idle", 0, 0, 0);
        bus.req_i = 4'b0110;
        #1;
        chk("reset_comb", 1, 1, 0);
        bus.req_i = '0;
        @(negedge clk);
        arst = 1'b1;

        // idle update ignored, plain RR, weighted RR, packet lock
        add(4'b0000, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(4'b1111, 0, 1, 1, i % 4, 1, 0);
        for (int i = 0; i < 8; i++)
            add(4'b1010, wp(0, 2, 0, 0), 1, 1,
                (i % 4 == 3) ? 3 : 1, 1, 0);
        add(4'b0011, 0, 1, 0, 0, 1, 0);
        add(4'b0011, 0, 1, 0, 0, 1, 1);
        add(4'b0011, 0, 1, 1, 0, 1, 1);
        add(4'b0011, 0, 0, 0, 1, 1, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].wt, tbl[i].upd, tbl[i].last);
            chk($sformatf("vec%0d", i), tbl[i].evalid, tbl[i].eidx,
                tbl[i].elock);
            adv();
        end

        // locked requester drops its request
        do_reset();
        drive(4'b0100, 0, 1, 0); adv();
        drive(4'b0001, 0, 1, 1);
        chk("lockdrop1", 0, 0, 1); adv();
        drive(4'b0001, 0, 1, 1);
        chk("lockdrop2", 0, 0, 1); adv();
        drive(4'b0101, 0, 0, 0);
        chk("lockback", 1, 2, 1); adv();
        drive(4'b0101, 0, 1, 1); adv();
        drive(4'b0101, 0, 0, 0);
        chk("lockrel", 1, 0, 0); adv();

        // top requester wraps the mask
        do_reset();
        drive(4'b1000, 0, 1, 1);
        chk("wrap_g3", 1, 3, 0); adv();
        drive(4'b1001, 0, 0, 0);
        chk("wrap_g0", 1, 0, 0); adv();

        // async reset in the middle of a locked packet
        do_reset();
        drive(4'b0010, 0, 1, 0); adv();
        drive(4'b0010, 0, 0, 0);
        chk("midlock", 1, 1, 1);
        #2 arst = 1'b0;
        mdl_reset();
        #1;
        chk("arst_unlock", 1, 1, 0);
        @(negedge clk);
        arst = 1'b1;
        drive(4'b0110, wp(0, 1, 0, 0), 1, 1);
        chk("post_rst_a", 1, 1, 0); adv();
        drive(4'b0110, wp(0, 1, 0, 0), 1, 1);
        chk("post_rst_b", 1, 1, 0); adv();
        drive(4'b0110, wp(0, 1, 0, 0), 1, 1);
        chk("post_rst_c", 1, 2, 0); adv();

        // random traffic against the model
        begin
            logic [11:0] w;
            w = 12'($urandom);
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 15) == 0) w = 12'($urandom);
                drive(4'($urandom), w, $urandom_range(0, 9) < 7,
                      $urandom_range(0, 1) == 1);
                adv();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
